plot_buffer: RTL and testbench
==============================

Name: plot_buffer

Overview:
- Downstream stage of the screen-fill engine.
- Accepts the per-cycle pixel stream (x, y, colour, plot strobe) and buffers it in a small synchronous FIFO.
- Drains the FIFO into the framebuffer write port as linear address = y*160 + x, honouring memory backpressure.
- Discards off-screen pixels and counts them. Propagates the upstream done once every buffered pixel is written.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- SCREEN_W, 160, pixel columns; x valid range 0..159.
- SCREEN_H, 120, pixel rows; y valid range 0..119.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_x  in  8  pixel column from the fill engine
- in_y  in  7  pixel row
- in_colour  in  3  pixel colour
- in_plot  in  1  pixel valid strobe
- in_ready  out  1  buffer can accept; equals not-full
- in_done  in  1  upstream done level (held high until reset)
- fb_addr  out  15  framebuffer word address
- fb_data  out  3  framebuffer colour
- fb_we  out  1  write request; high while the FIFO is non-empty
- fb_ready  in  1  framebuffer accepts the write this cycle
- out_done  out  1  all pixels drained and upstream done
- drop_count  out  CNT_W  off-screen pixels discarded since reset

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO is emptied; read and write pointers and occupancy are set to 0.
  - in_ready=1, fb_we=0, fb_addr=0, fb_data=0, out_done=0, drop_count=0.
  - Reset asserted mid-burst discards all buffered pixels; no write is issued after reset asserts.
- Accept:
  - A pixel is accepted on an edge when in_plot && in_ready.
  - Not-full is evaluated before that edge's pop. A push into a full FIFO is never allowed, even when a pop occurs on the same edge.
- Range check at accept:
  - A pixel is in range when in_x < SCREEN_W and in_y < SCREEN_H.
  - In range: the pixel is stored.
  - Out of range: the handshake completes but the pixel is not stored, and drop_count increments. drop_count saturates at all-ones.
- Address:
  - Computed at accept, 15-bit: (y<<7) + (y<<5) + x.
  - Maximum address is 19199; no multiplier.
  - Each stored entry is {addr[14:0], colour[2:0]}.
- Output (show-ahead FIFO):
  - fb_addr and fb_data are the FIFO head; fb_we = not empty.
  - fb_addr and fb_data hold at their last value when the FIFO is empty.
  - Pop occurs on an edge when fb_we && fb_ready.
  - fb_addr and fb_data stay stable while fb_we=1 and fb_ready=0.
- Latency:
  - A pixel accepted into an empty FIFO on edge N drives fb_we=1 in the cycle following edge N.
  - With fb_ready held high, throughput is 1 pixel per clock and the FIFO never fills.
- Simultaneous push and pop:
  - Occupancy is unchanged; both pointers advance.
  - Pointers wrap modulo DEPTH.
  - Full and empty are distinguished by an occupancy counter of width log2(DEPTH)+1.
- Done:
  - out_done is registered.
  - It is set on an edge where in_done=1, the FIFO is empty after that edge's updates, and no in-range pixel was accepted on that edge.
  - Once set, it stays high until reset.
  - If in_done rises while entries remain, out_done waits until the last pop.
- Control states:
  - IDLE: FIFO empty, in_done=0. Moves to ACTIVE on the first accept; moves to DRAIN if in_done rises.
  - ACTIVE: pushes and/or pops in flight. Moves to DRAIN when in_done is seen.
  - DRAIN: in_done high, entries remain. Moves to FINISHED when empty.
  - FINISHED: out_done=1; held until reset.
- Pixels accepted after in_done are still stored and written. out_done is not reasserted late: it stays high once set.

Decomposition:
- Shared package vga_pkg holds:
  - SCREEN_W, SCREEN_H, FB_ADDR_W=15, COLOUR_W=3
  - typedef struct packed pixel_t {x[7:0], y[6:0], colour[2:0]}
  - typedef fb_word_t {addr, colour}
  - function xy_to_addr
  - state enum for the done tracker
- One sub-module: plot_fifo, a parameterised synchronous show-ahead FIFO (DEPTH, WIDTH) with push, pop, full, empty, count.
- plot_buffer owns the range check, address calculation, drop counter and done tracker.

Test Plan:
- Single pixel: after reset, drive x=3, y=2, colour=5, plot for 1 cycle with fb_ready=1 → next cycle fb_we=1, fb_addr=323, fb_data=5; fb_we=0 the cycle after.
- Backpressure: fb_ready=0, push 8 pixels → in_ready=0 after the 8th, and the 9th is held off. Raise fb_ready → 8 writes in order, addresses unchanged while stalled.
- Boundaries: push (159,119), (160,0), (0,120), (0,0) → writes at 19199 and 0 only; drop_count=2.
- Full stream: connect the fill engine, 160×120 pixels, fb_ready random 50% → exactly 19200 writes covering every address once; out_done rises only after the last pop; drop_count=0.
- Done ordering: 3 pixels buffered with fb_ready=0, then in_done=1 → out_done stays 0; enable fb_ready → out_done=1 on the edge after the 3rd pop.
- Reset mid-operation: 5 entries buffered, pulse rst_n low asynchronously between edges → fb_we=0, in_ready=1, drop_count=0, out_done=0 immediately; no stale writes afterwards.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared screen geometry, pixel/framebuffer word layouts and the done-tracker
// state encoding for the VGA fill path.
package vga_pkg;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int FB_ADDR_W = 15;
  localparam int COLOUR_W  = 3;

  typedef struct packed {
    logic [7:0]          x;
    logic [6:0]          y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [COLOUR_W-1:0]  colour;
  } fb_word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DRAIN,
    ST_FINISHED
  } done_state_t;

  // y*160 + x as two shifts and an add; 119*160+159 = 19199 fits in 15 bits.
  function automatic logic [FB_ADDR_W-1:0] xy_to_addr(input logic [7:0] x,
                                                      input logic [6:0] y);
    logic [FB_ADDR_W-1:0] yw;
    logic [FB_ADDR_W-1:0] xw;
    yw = {8'd0, y};
    xw = {7'd0, x};
    return (yw << 7) + (yw << 5) + xw;
  endfunction

endpackage

// File: rtl/plot_fifo.sv
// Synchronous show-ahead FIFO: the head word is visible on rdata while not
// empty, and rdata holds the last popped word once the FIFO runs dry.
module plot_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 18
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;
  logic [WIDTH-1:0] last_q;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the pre-edge occupancy, so a pop never makes room for a
  // push on the same edge.
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      last_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        last_q <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/plot_buffer.sv
// Buffers the fill engine's pixel stream and drains it into the framebuffer
// write port, dropping off-screen pixels and forwarding done after the drain.
module plot_buffer #(
  parameter int DEPTH    = 8,
  parameter int SCREEN_W = vga_pkg::SCREEN_W,
  parameter int SCREEN_H = vga_pkg::SCREEN_H,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_x,
  input  logic [6:0]       in_y,
  input  logic [2:0]       in_colour,
  input  logic             in_plot,
  output logic             in_ready,
  input  logic             in_done,
  output logic [14:0]      fb_addr,
  output logic [2:0]       fb_data,
  output logic             fb_we,
  input  logic             fb_ready,
  output logic             out_done,
  output logic [CNT_W-1:0] drop_count
);

  import vga_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [7:0]       X_LIM   = 8'(SCREEN_W);
  localparam logic [6:0]       Y_LIM   = 7'(SCREEN_H);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [CNT_W-1:0] DROP_ONE = CNT_W'(1);

  pixel_t         px;
  fb_word_t       wr_word;
  fb_word_t       rd_word;
  logic           fifo_full;
  logic           fifo_empty;
  logic [PTR_W:0] fifo_count;
  logic           accept;
  logic           in_range;
  logic           push;
  logic           pop;
  logic           empty_after;
  logic           done_set;
  done_state_t    state_q;
  done_state_t    state_d;

  assign px       = '{x: in_x, y: in_y, colour: in_colour};
  assign in_ready = !fifo_full;
  assign accept   = in_plot && in_ready;
  assign in_range = (px.x < X_LIM) && (px.y < Y_LIM);
  assign push     = accept && in_range;
  assign fb_we    = !fifo_empty;
  assign pop      = fb_we && fb_ready;
  assign wr_word  = '{addr: xy_to_addr(px.x, px.y), colour: px.colour};
  assign fb_addr  = rd_word.addr;
  assign fb_data  = rd_word.colour;

  plot_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fb_word_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wr_word),
    .pop   (pop),
    .rdata (rd_word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (accept && !in_range && (drop_count != '1)) begin
      drop_count <= drop_count + DROP_ONE;
    end
  end

  // Occupancy after this edge is zero only if nothing is pushed and either the
  // FIFO is already empty or its last entry is popped now.
  assign empty_after = fifo_empty || ((fifo_count == CNT_ONE) && pop);
  assign done_set    = in_done && !push && empty_after;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (done_set)     state_d = ST_FINISHED;
        else if (in_done) state_d = ST_DRAIN;
        else if (accept)  state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (done_set)     state_d = ST_FINISHED;
        else if (in_done) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (done_set)     state_d = ST_FINISHED;
      end
      default: state_d = ST_FINISHED;
    endcase
  end

  assign out_done = (state_q == ST_FINISHED);

endmodule

// File: tb/tb_plot_buffer.sv
// Directed bench for plot_buffer: reset, single pixel, backpressure, range
// boundaries, done ordering, asynchronous reset and a full-screen stream.
module tb_plot_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_x;
  logic [6:0]  in_y;
  logic [2:0]  in_colour;
  logic        in_plot;
  logic        in_ready;
  logic        in_done;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_we;
  logic        fb_ready;
  logic        out_done;
  logic [15:0] drop_count;

  int n_vec = 0;
  int n_err = 0;

  bit seen [19200];
  int idx, writes, cycles, dups, order_err, early, stale;
  bit accepted;

  plot_buffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_colour  (in_colour),
    .in_plot    (in_plot),
    .in_ready   (in_ready),
    .in_done    (in_done),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_we      (fb_we),
    .fb_ready   (fb_ready),
    .out_done   (out_done),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_px(input int x, input int y, input int c);
    in_x      = 8'(x);
    in_y      = 7'(y);
    in_colour = 3'(c);
    in_plot   = 1'b1;
    step();
    in_plot   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_x = '0; in_y = '0; in_colour = '0;
    in_plot = 1'b0; in_done = 1'b0; fb_ready = 1'b0;
    #2;
    check("rst_in_ready",   32'(in_ready),   1);
    check("rst_fb_we",      32'(fb_we),      0);
    check("rst_fb_addr",    32'(fb_addr),    0);
    check("rst_fb_data",    32'(fb_data),    0);
    check("rst_out_done",   32'(out_done),   0);
    check("rst_drop_count", 32'(drop_count), 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // single pixel: (3,2) -> 2*160+3 = 323
    fb_ready = 1'b1;
    push_px(3, 2, 5);
    check("single_we",   32'(fb_we),   1);
    check("single_addr", 32'(fb_addr), 323);
    check("single_data", 32'(fb_data), 5);
    step();
    check("single_we_off", 32'(fb_we),   0);
    check("single_hold",   32'(fb_addr), 323);

    // backpressure: 8 pixels on row 1 -> addresses 160..167
    fb_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_px(i, 1, i);
      check("bp_in_ready", 32'(in_ready), (i < 7) ? 1 : 0);
    end
    in_x = 8'd50; in_y = 7'd1; in_colour = 3'd7; in_plot = 1'b1;
    step();
    in_plot = 1'b0;
    check("bp_ninth_held", 32'(in_ready), 0);
    check("bp_stall_addr", 32'(fb_addr), 160);
    fb_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("bp_drain_we",   32'(fb_we),   1);
      check("bp_drain_addr", 32'(fb_addr), 160 + i);
      check("bp_drain_data", 32'(fb_data), i);
      step();
    end
    check("bp_empty_we", 32'(fb_we),   0);
    check("bp_hold",     32'(fb_addr), 167);

    // boundaries: only (159,119) and (0,0) stored
    fb_ready = 1'b0;
    push_px(159, 119, 1);
    push_px(160, 0, 2);
    push_px(0, 120, 3);
    push_px(0, 0, 4);
    check("bnd_drop_count", 32'(drop_count), 2);
    check("bnd_addr_max",   32'(fb_addr),    19199);
    check("bnd_data_max",   32'(fb_data),    1);
    fb_ready = 1'b1;
    step();
    check("bnd_we_second",   32'(fb_we),   1);
    check("bnd_addr_zero",   32'(fb_addr), 0);
    check("bnd_data_zero",   32'(fb_data), 4);
    step();
    check("bnd_we_off",      32'(fb_we),   0);

    // done ordering
    fb_ready = 1'b0;
    push_px(1, 0, 1);
    push_px(2, 0, 2);
    push_px(3, 0, 3);
    in_done = 1'b1;
    step(); step();
    check("done_wait", 32'(out_done), 0);
    fb_ready = 1'b1;
    step();
    check("done_pop1", 32'(out_done), 0);
    step();
    check("done_pop2", 32'(out_done), 0);
    step();
    check("done_pop3", 32'(out_done), 1);
    check("done_we",   32'(fb_we),    0);
    step();
    check("done_sticky", 32'(out_done), 1);

    // asynchronous reset mid-burst
    fb_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_px(10 + i, 5, i);
    check("ar_buffered", 32'(fb_we), 1);
    #3;
    rst_n = 1'b0; in_done = 1'b0;
    #1;
    check("ar_fb_we",      32'(fb_we),      0);
    check("ar_in_ready",   32'(in_ready),   1);
    check("ar_drop_count", 32'(drop_count), 0);
    check("ar_out_done",   32'(out_done),   0);
    check("ar_fb_addr",    32'(fb_addr),    0);
    #1;
    rst_n = 1'b1;
    fb_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      step();
      if (fb_we) stale++;
    end
    check("ar_no_stale", 32'(stale), 0);

    // full screen stream in raster order with random backpressure
    idx = 0; writes = 0; cycles = 0; dups = 0; order_err = 0; early = 0;
    while (writes < 19200 && cycles < 80000) begin
      fb_ready = 1'($urandom_range(0, 1));
      in_plot  = (idx < 19200);
      in_done  = (idx >= 19200);
      in_x     = 8'(idx % 160);
      in_y     = 7'(idx / 160);
      in_colour = 3'(idx);
      #1;
      if (out_done) early++;
      if (fb_we && fb_ready) begin
        if (int'(fb_addr) != writes) order_err++;
        if (int'(fb_addr) < 19200) begin
          if (seen[fb_addr]) dups++;
          seen[fb_addr] = 1'b1;
        end
        writes++;
      end
      accepted = in_plot && in_ready;
      step();
      if (accepted) idx++;
      cycles++;
    end
    in_plot = 1'b0;
    check("fs_writes",     32'(writes),     19200);
    check("fs_order",      32'(order_err),  0);
    check("fs_dups",       32'(dups),       0);
    check("fs_early_done", 32'(early),      0);
    check("fs_out_done",   32'(out_done),   1);
    check("fs_drop_count", 32'(drop_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
